compare_serial: RTL and testbench
=================================

COMPARE_SERIAL -- requirements
Module: compare_serial

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, at least 2.
REQ-002 Parameter DIGIT, default 4: bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 Port clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port start  input  1  request a compare; sampled on clk.
REQ-006 Port is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 Port A  input  WIDTH  operand A; sampled with start.
REQ-008 Port B  input  WIDTH  operand B; sampled with start.
REQ-009 Port busy  output  1  high while a compare is in progress (state RUN or DONE).
REQ-010 Port done  output  1  one-cycle pulse: result flags valid.
REQ-011 Port AeqB  output  1  registered result, A == B.
REQ-012 Port AgtB  output  1  registered result, A > B.
REQ-013 Port AltB  output  1  registered result, A < B.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: on an edge with start=1, the block SHALL latch A, B, is_signed, set digit index i=0, clear AeqB/AgtB/AltB to 0 and enter RUN; start=0 leaves it in IDLE.
REQ-016 Signed mode: at capture, bit WIDTH-1 of both latched operands SHALL be inverted, and all later compares SHALL be unsigned on the modified values.
REQ-017 RUN: each cycle SHALL compare digit i (i=0 is bits WIDTH-1..WIDTH-DIGIT, MSB first) of latched A against latched B.
REQ-018 RUN, digits differ: at that edge, AgtB or AltB SHALL be set per the digit compare and the state SHALL go to DONE (early termination).
REQ-019 RUN, digits equal, i < N-1: i SHALL increment and the state SHALL stay RUN.
REQ-020 RUN, digits equal, i = N-1: AeqB SHALL be set and the state SHALL go to DONE.
REQ-021 DONE: done SHALL be 1 for exactly this one cycle, then the state SHALL go to IDLE unconditionally.
REQ-022 Latency: with k the 0-based index of the first differing digit (k = N-1 if equal), done SHALL assert k+1 cycles after the start-sampling edge; min 1, max N.
REQ-023 After done, exactly one of AeqB/AgtB/AltB SHALL be 1, and the flags SHALL hold until the next accepted start.
REQ-024 start while busy=1 (RUN or DONE) SHALL be ignored, with no effect on latched operands or flags.
REQ-025 Changes on A, B or is_signed after capture SHALL NOT affect the compare in progress.
REQ-026 busy SHALL be a registered decode of the state (1 in RUN and DONE); start accepted at edge e SHALL give busy=1 from edge e.
REQ-027 Back-to-back: start high in the cycle after done (state IDLE) SHALL be accepted; peak throughput is one compare per k+3 cycles.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, i=0, busy=0, done=0, AeqB=AgtB=AltB=0, and clear the latched operands, regardless of clk.
REQ-029 Reset asserted during RUN or DONE SHALL abort the compare; no done pulse SHALL follow, and the first edge after release SHALL behave as IDLE.
REQ-030 All flags SHALL read 0 from reset until the first done.

Verification (WIDTH=16, DIGIT=4 unless noted)
REQ-031 A=0x1234, B=0x1234, unsigned -> done 4 cycles after start, AeqB=1, others 0.
REQ-032 A=0x8000, B=0x7FFF -> unsigned: AgtB=1, done after 1 cycle; signed: AltB=1, done after 1 cycle.
REQ-033 A=0x12F4, B=0x1204, unsigned -> AgtB=1, done after 3 cycles; A=0xFFFF, B=0xFFFE, signed -> AgtB=1 after 4 cycles.
REQ-034 start pulsed on the 2nd RUN cycle with different operands -> first result unchanged, busy continuous, one done pulse only.
REQ-035 rst_n low in 2nd RUN cycle of an equal compare -> all outputs 0 at once, no done; a new start after release completes normally.
REQ-036 WIDTH=8, DIGIT=1, A=0x01, B=0x00 -> AgtB=1, done after 8 cycles; WIDTH=8, DIGIT=8 -> every result after 1 cycle.

Source files
------------

// File: rtl/compare_serial.sv
// Digit-serial magnitude comparator: compares A and B one DIGIT-wide slice per cycle, MSB first,
// stopping at the first differing digit. Signed mode flips both sign bits at capture.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; result flags hold the last compare
// RUN   | comparing digit idx of the latched operands
// DONE  | one-cycle result-valid pulse, then back to IDLE
module compare_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AeqB,
    output logic             AgtB,
    output logic             AltB
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    idx, idx_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-1:0] sign_flip;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             eq_nx, gt_nx, lt_nx;
    logic             load;

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};

    always_comb begin
        a_sh  = a_q << (int'(idx) * DIGIT);
        b_sh  = b_q << (int'(idx) * DIGIT);
        dig_a = a_sh[WIDTH-1 -: DIGIT];
        dig_b = b_sh[WIDTH-1 -: DIGIT];
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        eq_nx    = AeqB;
        gt_nx    = AgtB;
        lt_nx    = AltB;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    idx_nx   = '0;
                    eq_nx    = 1'b0;
                    gt_nx    = 1'b0;
                    lt_nx    = 1'b0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (dig_a > dig_b) begin
                    gt_nx    = 1'b1;
                    state_nx = DONE;
                end else if (dig_a < dig_b) begin
                    lt_nx    = 1'b1;
                    state_nx = DONE;
                end else if (idx == LAST) begin
                    eq_nx    = 1'b1;
                    state_nx = DONE;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            AeqB  <= 1'b0;
            AgtB  <= 1'b0;
            AltB  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (load) begin
                a_q <= A ^ sign_flip;
                b_q <= B ^ sign_flip;
            end
            // busy/done decode the next state so they line up with the state register.
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
            AeqB  <= eq_nx;
            AgtB  <= gt_nx;
            AltB  <= lt_nx;
        end
    end

endmodule

// File: tb/tb_compare_serial.sv
// Scoreboard bench for compare_serial: three instances (16/4, 8/1, 8/8); stimulus pushes the
// expected flags and done cycle, a negedge monitor pops and checks on every done pulse.
module tb_compare_serial;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic [2:0]  sgn_v   = '0;
    logic [15:0] a_v [3];
    logic [15:0] b_v [3];

    logic busy0, done0, eq0, gt0, lt0;
    logic busy1, done1, eq1, gt1, lt1;
    logic busy2, done2, eq2, gt2, lt2;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] flags;
        int         at;
    } exp_t;

    exp_t sbq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    compare_serial #(.WIDTH(16), .DIGIT(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .is_signed(sgn_v[0]),
        .A(a_v[0]), .B(b_v[0]),
        .busy(busy0), .done(done0), .AeqB(eq0), .AgtB(gt0), .AltB(lt0));

    compare_serial #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .is_signed(sgn_v[1]),
        .A(a_v[1][7:0]), .B(b_v[1][7:0]),
        .busy(busy1), .done(done1), .AeqB(eq1), .AgtB(gt1), .AltB(lt1));

    compare_serial #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .is_signed(sgn_v[2]),
        .A(a_v[2][7:0]), .B(b_v[2][7:0]),
        .busy(busy2), .done(done2), .AeqB(eq2), .AgtB(gt2), .AltB(lt2));

    function automatic logic [2:0] flags_of(input int d);
        case (d)
            0:       return {eq0, gt0, lt0};
            1:       return {eq1, gt1, lt1};
            default: return {eq2, gt2, lt2};
        endcase
    endfunction

    function automatic logic busy_of(input int d);
        case (d)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic done_of(input int d);
        case (d)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (done_of(d)) begin
                if (sbq[d].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done[%0d]: got done=1 expected none (cycle %0d)", d, cyc);
                end else begin
                    e = sbq[d].pop_front();
                    chk($sformatf("result_flags[%0d]", d), 32'(flags_of(d)), 32'(e.flags));
                    chk($sformatf("done_cycle[%0d]", d), cyc, e.at);
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy_of(d) && t < 40);
        if (busy_of(d)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout[%0d]: busy still 1 after %0d cycles", d, t);
        end
    endtask

    // Called in the low clock phase; returns at a negedge with the instance back in IDLE.
    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [2:0] f, input int k);
        exp_t e;
        a_v[d]     = a;
        b_v[d]     = b;
        sgn_v[d]   = s;
        start_v[d] = 1'b1;
        e.flags    = f;
        e.at       = cyc + 2 + k;
        sbq[d].push_back(e);
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        a_v[d]     = ~a;
        b_v[d]     = a;
        sgn_v[d]   = ~s;
        chk($sformatf("busy_after_start[%0d]", d), 32'(busy_of(d)), 32'd1);
        wait_idle(d);
        chk($sformatf("flags_hold[%0d]", d), 32'(flags_of(d)), 32'(f));
    endtask

    initial begin
        exp_t e;
        int   t;
        for (int d = 0; d < 3; d++) begin
            a_v[d] = '0;
            b_v[d] = '0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_busy_done[%0d]", d), 32'({busy_of(d), done_of(d)}), 32'd0);
            chk($sformatf("reset_flags[%0d]", d), 32'(flags_of(d)), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("flags_zero_after_release", 32'(flags_of(0)), 32'd0);

        // 16-bit, 4-bit digits
        issue(0, 16'h1234, 16'h1234, 1'b0, EQ, 3);
        issue(0, 16'h8000, 16'h7FFF, 1'b0, GT, 0);
        issue(0, 16'h8000, 16'h7FFF, 1'b1, LT, 0);
        issue(0, 16'h12F4, 16'h1204, 1'b0, GT, 2);
        issue(0, 16'hFFFF, 16'hFFFE, 1'b1, GT, 3);
        issue(0, 16'h0005, 16'hFFFB, 1'b1, GT, 0);
        issue(0, 16'hFFFB, 16'h0005, 1'b1, LT, 0);
        issue(0, 16'h1230, 16'h1239, 1'b0, LT, 3);
        issue(0, 16'h8000, 16'h8000, 1'b1, EQ, 3);

        // start during RUN must be ignored
        a_v[0] = 16'h1234; b_v[0] = 16'h1234; sgn_v[0] = 1'b0; start_v[0] = 1'b1;
        e.flags = EQ; e.at = cyc + 2 + 3;
        sbq[0].push_back(e);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        a_v[0] = 16'hF000; b_v[0] = 16'h0000; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        t = 0;
        while (!done0 && t < 20) begin
            @(negedge clk);
            chk("busy_continuous", 32'(busy0), 32'd1);
            t++;
        end
        wait_idle(0);
        chk("ignored_start_flags", 32'(flags_of(0)), 32'(EQ));
        repeat (3) @(negedge clk);
        chk("no_second_run", 32'(busy0), 32'd0);

        // reset in the middle of a compare
        a_v[0] = 16'h5555; b_v[0] = 16'h5555; start_v[0] = 1'b1;
        e.flags = EQ; e.at = cyc + 2 + 3;
        sbq[0].push_back(e);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy_done", 32'({busy0, done0}), 32'd0);
        chk("abort_flags", 32'(flags_of(0)), 32'd0);
        sbq[0].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_still_idle", 32'({busy0, done0, flags_of(0)}), 32'd0);
        issue(0, 16'h00FF, 16'h00FE, 1'b0, GT, 3);

        // 8-bit, 1-bit digits
        issue(1, 16'h0001, 16'h0000, 1'b0, GT, 7);
        issue(1, 16'h0080, 16'h007F, 1'b0, GT, 0);
        issue(1, 16'h0080, 16'h007F, 1'b1, LT, 0);
        issue(1, 16'h00A5, 16'h00A5, 1'b1, EQ, 7);

        // 8-bit, single digit
        issue(2, 16'h0001, 16'h0000, 1'b0, GT, 0);
        issue(2, 16'h0080, 16'h007F, 1'b1, LT, 0);
        issue(2, 16'h005A, 16'h005A, 1'b0, EQ, 0);

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("scoreboard_drained[%0d]", d), 32'(sbq[d].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
